// File: rtl/wavesense_dsp_pkg.sv
// rtl/wavesense_dsp_pkg.sv - shared DSP types, constants and saturation helper
package wavesense_dsp_pkg;

  typedef logic signed [31:0] sample_t;

  // FIR coefficient sum is 153, so a 7-bit shift brings unity gain back near 1.2
  localparam int FIR_GAIN_SHIFT = 7;
  // 122.88 MS/s down to 20.48 MS/s
  localparam int DECIM_20M      = 6;

  // Clamp a wide signed value to the signed range of a width-bit word
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] x,
                                                input int                  width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/fir_decimator_round_sat.sv
// rtl/fir_decimator_round_sat.sv - combinational arithmetic shift and saturate with clip flag
module round_sat
  import wavesense_dsp_pkg::*;
#(
  parameter int IN_W      = 33,
  parameter int SHIFT     = 7,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [IN_W-1:0]      i_a,
  output logic signed [OUT_WIDTH-1:0] o_y,
  output logic                        o_clip
);

  logic signed [IN_W-1:0] w_shifted;
  logic signed [63:0]     w_wide;
  logic signed [63:0]     w_sat;

  // Rounding constant was already added upstream, so a plain arithmetic shift completes round-half-up
  assign w_shifted = i_a >>> SHIFT;
  assign w_wide    = 64'(w_shifted);
  assign w_sat     = sat_to(w_wide, OUT_WIDTH);
  assign o_y       = w_sat[OUT_WIDTH-1:0];
  assign o_clip    = (w_sat != w_wide);

endmodule

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - keep 1 of DECIM samples, round, saturate, stream out; DECIM_SAT_COUNT_EN adds clip counter
module fir_decimator
  import wavesense_dsp_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int OUT_WIDTH              = 16,
  parameter int DECIM                  = DECIM_20M,
  parameter int SHIFT                  = FIR_GAIN_SHIFT
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  output logic                              s00_axis_tready,
`ifdef DECIM_SAT_COUNT_EN
  input  logic                              sat_clear,
  output logic [15:0]                       sat_count,
`endif
  input  logic                              m00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata
);

  localparam int IW = C_S00_AXIS_TDATA_WIDTH;
  localparam int AW = IW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [AW-1:0] RND =
    (SHIFT == 0) ? AW'(0) : (AW'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));

  generate
    if (DECIM < 1) begin : g_bad_decim
      $error("fir_decimator: DECIM must be >= 1");
    end
    if (OUT_WIDTH > C_M00_AXIS_TDATA_WIDTH) begin : g_bad_width
      $error("fir_decimator: OUT_WIDTH must not exceed C_M00_AXIS_TDATA_WIDTH");
    end
  endgenerate

  logic [PW-1:0]              r_phase;
  logic                       r_va;
  logic                       r_vb;
  logic signed [AW-1:0]       r_a;
  logic signed [OUT_WIDTH-1:0] r_b;

  logic                       w_adv;
  logic                       w_accept;
  logic                       w_keep;
  logic signed [AW-1:0]       w_a_next;
  logic signed [OUT_WIDTH-1:0] w_y;
`ifdef DECIM_SAT_COUNT_EN
  logic                       w_clip;
`else
  logic                       w_clip_unused;
`endif

  // Whole pipeline moves together; it only freezes when the output holds an unaccepted beat
  assign w_adv           = ~r_vb | m00_axis_tready;
  assign w_accept        = s00_axis_tvalid & w_adv;
  assign w_keep          = (r_phase == '0);
  assign w_a_next        = $signed({s00_axis_tdata[IW-1], s00_axis_tdata}) + RND;
  assign s00_axis_tready = w_adv;
  assign m00_axis_tvalid = r_vb;
  assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(r_b);

  round_sat #(
    .IN_W      (AW),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .i_a    (r_a),
    .o_y    (w_y),
`ifdef DECIM_SAT_COUNT_EN
    .o_clip (w_clip)
`else
    .o_clip (w_clip_unused)
`endif
  );

  // Decimation phase: counts accepted beats only, so input gaps never shift the kept grid
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_phase <= '0;
    end else if (w_accept) begin
      r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + PW'(1);
    end
  end

  // Stage A captures the rounded input, stage B the shifted and saturated result
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_va <= 1'b0;
      r_vb <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_adv) begin
      r_va <= w_accept & w_keep;
      r_a  <= w_a_next;
      r_vb <= r_va;
      r_b  <= w_y;
    end
  end

`ifdef DECIM_SAT_COUNT_EN
  logic [15:0] r_sat_count;
  assign sat_count = r_sat_count;

  // Count valid stage-B loads that clipped; saturates at all-ones, clear has priority
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_sat_count <= '0;
    end else if (sat_clear) begin
      r_sat_count <= '0;
    end else if (w_adv && r_va && w_clip && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - scoreboard bench for fir_decimator (DECIM=6, SHIFT=7, OUT_WIDTH=16)
`timescale 1ns/1ps
module tb_fir_decimator;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata  = '0;
  logic        s_tready;
  logic        m_tready = 1'b1;
  logic        m_tvalid;
  logic [31:0] m_tdata;
`ifdef DECIM_SAT_COUNT_EN
  logic        sat_clear = 1'b0;
  logic [15:0] sat_count;
`endif

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          tb_phase = 0;
  bit          lat_chk  = 1'b0;
  int          n_exp    = 0;
  int          n_out    = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic [31:0] got_q[$];

  fir_decimator dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tready  (s_tready),
`ifdef DECIM_SAT_COUNT_EN
    .sat_clear        (sat_clear),
    .sat_count        (sat_count),
`endif
    .m00_axis_tready  (m_tready),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tdata   (m_tdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] x);
    longint v;
    v = longint'($signed(x)) + 64;
    v = v >>> 7;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return 32'(v);
  endfunction

  // Scoreboard: push on accepted kept input, pop and compare on output handshake
  always @(negedge clk) begin
    logic [31:0] e;
    int          a;
    if (!rst_n) begin
      tb_phase = 0;
    end else begin
      if (s_tvalid && s_tready) begin
        if (tb_phase == 0) begin
          exp_q.push_back(model(s_tdata));
          acc_q.push_back(cyc);
          n_exp++;
        end
        tb_phase = (tb_phase == 5) ? 0 : tb_phase + 1;
      end
      if (m_tvalid && m_tready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_output got=%08h expected=none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          got_q.push_back(m_tdata);
          if (m_tdata !== e) begin
            failures++;
            $display("FAIL sb_data got=%08h expected=%08h", m_tdata, e);
          end
          if (lat_chk) begin
            checks++;
            if (cyc - a != 2) begin
              failures++;
              $display("FAIL latency got=%0d expected=2", cyc - a);
            end
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d);
    logic acc;
    int   n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=no_accept expected=accept");
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++; $display("FAIL reset_tvalid got=%b expected=0", m_tvalid);
    end
    checks++;
    if (m_tdata !== 32'h0) begin
      failures++; $display("FAIL reset_tdata got=%08h expected=00000000", m_tdata);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      failures++; $display("FAIL reset_tready got=%b expected=1", s_tready);
    end
`ifdef DECIM_SAT_COUNT_EN
    checks++;
    if (sat_count !== 16'h0) begin
      failures++; $display("FAIL reset_sat_count got=%0d expected=0", sat_count);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    got_q.delete();
    lat_chk = 1'b1;
    for (int x = 0; x < 60; x++) send_beat(32'(x * 128));
    drain();
    lat_chk = 1'b0;
    checks++;
    if (got_q.size() != 10 || exp_q.size() != 0) begin
      failures++; $display("FAIL ramp_count got=%0d expected=10", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      checks++;
      if (got_q[i] !== 32'(i * 6)) begin
        failures++; $display("FAIL ramp_value[%0d] got=%0d expected=%0d", i, got_q[i], i * 6);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vin [4];
    logic [31:0] vexp[4];
    vin  = '{32'd64, 32'd63, 32'hFFFF_FFC0, 32'hFFFF_FFBF};
    vexp = '{32'h0000_0001, 32'h0, 32'h0, 32'hFFFF_FFFF};
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_beat(vin[i]);
      repeat (5) send_beat(32'd0);
    end
    drain();
    checks++;
    if (got_q.size() != 4) begin
      failures++; $display("FAIL round_count got=%0d expected=4", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i] !== vexp[i]) begin
        failures++; $display("FAIL round_value[%0d] got=%08h expected=%08h", i, got_q[i], vexp[i]);
      end
    end
  endtask

  task automatic test_saturation();
`ifdef DECIM_SAT_COUNT_EN
    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_clear = 1'b0;
`endif
    got_q.delete();
    send_beat(32'h7FFF_FFFF);
    repeat (5) send_beat(32'd0);
    send_beat(32'h8000_0000);
    repeat (5) send_beat(32'd0);
    drain();
    checks++;
    if (got_q.size() != 2) begin
      failures++; $display("FAIL sat_count_out got=%0d expected=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 32'h0000_7FFF) begin
        failures++; $display("FAIL sat_pos got=%08h expected=00007fff", got_q[0]);
      end
      checks++;
      if (got_q[1] !== 32'hFFFF_8000) begin
        failures++; $display("FAIL sat_neg got=%08h expected=ffff8000", got_q[1]);
      end
    end
`ifdef DECIM_SAT_COUNT_EN
    checks++;
    if (sat_count !== 16'd2) begin
      failures++; $display("FAIL sat_counter got=%0d expected=2", sat_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    int   x;
    logic acc;
    got_q.delete();
    x = 0;
    for (int k = 0; x < 60 && k < 400; k++) begin
      m_tready = !(k >= 20 && k < 25);
      s_tvalid = 1'b1;
      s_tdata  = 32'(x * 128);
      @(negedge clk);
      if (k >= 20 && k < 25) begin
        checks++;
        if (m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
          failures++;
          $display("FAIL stall_handshake got=tvalid%b_tready%b expected=tvalid1_tready0", m_tvalid, s_tready);
        end
        checks++;
        if (m_tdata !== 32'd18) begin
          failures++; $display("FAIL stall_hold got=%0d expected=18", m_tdata);
        end
      end
      acc = s_tready;
      @(posedge clk);
      #1;
      if (acc) x++;
    end
    s_tvalid = 1'b0;
    drain();
    checks++;
    if (got_q.size() != 10 || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_count got=%0d expected=10", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      checks++;
      if (got_q[i] !== 32'(i * 6)) begin
        failures++; $display("FAIL bp_value[%0d] got=%0d expected=%0d", i, got_q[i], i * 6);
      end
    end
  endtask

  task automatic test_reset_midstream();
    m_tready = 1'b1;
    for (int x = 0; x < 6; x++) send_beat(32'(x * 128));
    m_tready = 1'b0;
    send_beat(32'(6 * 128));
    send_beat(32'(7 * 128));
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'd6) begin
      failures++; $display("FAIL midrst_pre got=tvalid%b_%0d expected=tvalid1_6", m_tvalid, m_tdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++; $display("FAIL midrst_tvalid got=%b expected=0", m_tvalid);
    end
    checks++;
    if (m_tdata !== 32'h0) begin
      failures++; $display("FAIL midrst_tdata got=%08h expected=00000000", m_tdata);
    end
    exp_q.delete();
    acc_q.delete();
    got_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    send_beat(32'd1280);
    for (int x = 11; x < 16; x++) send_beat(32'(x * 128));
    send_beat(32'd2560);
    drain();
    checks++;
    if (got_q.size() != 2) begin
      failures++; $display("FAIL midrst_count got=%0d expected=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 32'd10) begin
        failures++; $display("FAIL midrst_first got=%0d expected=10", got_q[0]);
      end
      checks++;
      if (got_q[1] !== 32'd20) begin
        failures++; $display("FAIL midrst_second got=%0d expected=20", got_q[1]);
      end
    end
  endtask

  task automatic test_random_gaps();
    int   exp0;
    int   out0;
    logic pending;
    logic acc;
    got_q.delete();
    exp0    = n_exp;
    out0    = n_out;
    pending = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      if (!pending) begin
        s_tvalid = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) s_tdata = $urandom;
        else s_tdata = 32'(int'($urandom_range(0, 2000000)) - 1000000);
      end
      m_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc     = s_tvalid & s_tready;
      pending = s_tvalid & ~acc;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rand_drops got=%0d_left expected=0_left", exp_q.size());
    end
    checks++;
    if ((n_out - out0) != (n_exp - exp0) || (n_exp - exp0) < 20) begin
      failures++; $display("FAIL rand_count got=%0d expected=%0d", n_out - out0, n_exp - exp0);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_reset_midstream();
    test_random_gaps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
